// File: rtl/apb_stdout_writer.sv
// APB3 initiator that drains a tagged character FIFO into the per-core stdout slave.
// Optional ACCESS-phase timeout is compiled in with APB_STDOUT_WR_TIMEOUT_EN.
module apb_stdout_writer #(
  parameter int unsigned          N_CORES    = 8,
  parameter int unsigned          N_CLUSTERS = 1,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned          FIFO_DEPTH = 8,
  parameter int unsigned          TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [7:0]            in_char_i,
  input  logic [3:0]            in_cl_i,
  input  logic [3:0]            in_core_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  busy_o,
  output logic                  drop_o,
  output logic                  err_o,
  input  logic                  clr_err_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  // FIFO entry layout: {cluster[3:0], core[3:0], char[7:0]}
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, rptr_nxt, count;
  logic          full, empty, id_ok, accept, push, pop;
  logic          drop_q;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  err_q, err_d, set_err, timeout;

  logic unused_prdata;
  assign unused_prdata = ^prdata_i;

  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [15:0] e);
    return BASE_ADDR + (ADDR_WIDTH'(e[15:12]) << 7) + (ADDR_WIDTH'(e[11:8]) << 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] entry_data(input logic [15:0] e);
    return DATA_WIDTH'(e[7:0]);
  endfunction

  assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty    = (wptr_q == rptr_q);
  assign count    = wptr_q - rptr_q;
  assign rptr_nxt = rptr_q + PW'(1);

  assign id_ok  = (32'(in_cl_i) < N_CLUSTERS) && (32'(in_core_i) < N_CORES);
  assign accept = in_valid_i && !full;
  assign push   = accept && id_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_nxt;
      drop_q <= accept && !id_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {in_cl_i, in_core_i, in_char_i};
  end

`ifdef APB_STDOUT_WR_TIMEOUT_EN
  logic [31:0] tmo_q;

  assign timeout = (state_q == StAccess) && !pready_i && (tmo_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (state_q == StAccess && state_d == StAccess) begin
      tmo_q <= tmo_q + 32'd1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pop       = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = 1'b1;
          paddr_d   = entry_addr(mem_q[rptr_q[AW-1:0]]);
          pwdata_d  = entry_data(mem_q[rptr_q[AW-1:0]]);
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (pready_i || timeout) begin
          pop     = 1'b1;
          set_err = (pready_i && pslverr_i) || timeout;
          // A push landing this same cycle is not yet counted; it is picked up from IDLE.
          if (count > PW'(1)) begin
            state_d   = StSetup;
            penable_d = 1'b0;
            paddr_d   = entry_addr(mem_q[rptr_nxt[AW-1:0]]);
            pwdata_d  = entry_data(mem_q[rptr_nxt[AW-1:0]]);
          end else begin
            state_d   = StIdle;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            paddr_d   = '0;
            pwdata_d  = '0;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
      end
    endcase

    err_d = err_q;
    if (clr_err_i) err_d = 1'b0;
    if (set_err)   err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      err_q     <= err_d;
    end
  end

  assign in_ready_o = !full;
  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign pwrite_o   = pwrite_q;
  assign paddr_o    = paddr_q;
  assign pwdata_o   = pwdata_q;
  assign busy_o     = (state_q != StIdle) || !empty;
  assign drop_o     = drop_q;
  assign err_o      = err_q;

endmodule
